// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR equalizer coefficient path.
// The FIR datapath imports the same defaults so both sides agree on set geometry.
package fir_ctrl_pkg;

  localparam int unsigned COEFF_W_DEFAULT = 32;
  localparam int unsigned TAP_DEFAULT     = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    PENDING
  } state_t;

endpackage

// File: rtl/coeff_bank.sv
// One TAP x WIDTH_coeff coefficient register bank with a single write port.
// The whole array is exposed so the FIR sees every tap in parallel.
module coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH_coeff = COEFF_W_DEFAULT,
  parameter int TAP         = TAP_DEFAULT,
  parameter int IDX_W       = $clog2(TAP)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_we,
  input  logic [IDX_W-1:0]                  i_waddr,
  input  logic [WIDTH_coeff-1:0]            i_wdata,
  output logic [TAP-1:0][WIDTH_coeff-1:0]   o_coeffs
);

  logic [TAP-1:0][WIDTH_coeff-1:0] r_coeffs;

  // NOTE: this array is reset on purpose: a zeroed bank is the mute state the
  // FIR must see after reset, so it cannot be left as an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coeffs <= '0;
    end else if (i_we) begin
      r_coeffs[i_waddr] <= i_wdata;
    end
  end

  assign o_coeffs = r_coeffs;

endmodule

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: fills the shadow bank from a beat
// stream and swaps it in only on an audio sample strobe after a commit.
module fir_coeff_loader
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH_coeff = COEFF_W_DEFAULT,
  parameter int TAP         = TAP_DEFAULT,
  parameter int IDX_W       = $clog2(TAP)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sample_en,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic signed [WIDTH_coeff-1:0]          load_data,
  input  logic                                   load_last,
  input  logic                                   commit,
  input  logic                                   clear_err,
  output logic        [TAP-1:0][WIDTH_coeff-1:0] h_out,
  output logic                                   bank_sel,
  output logic                                   swap_pending,
  output logic                                   swap_done,
  output logic                                   err_len,
  output logic        [IDX_W-1:0]                wr_idx
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_bank_sel;
  logic             r_swap_done;
  logic             r_err_len;
  logic             w_beat;
  logic             w_err_set;
  logic             w_swap;

  logic [TAP-1:0][WIDTH_coeff-1:0] w_bank0;
  logic [TAP-1:0][WIDTH_coeff-1:0] w_bank1;

  assign load_ready   = (r_state == IDLE) || (r_state == LOAD);
  assign swap_pending = (r_state == PENDING);
  assign w_beat       = load_valid & load_ready;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_wr_idx;
    w_err_set   = 1'b0;
    w_swap      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_beat) begin
          if (load_last) begin
            w_err_set = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_beat) begin
          if (r_wr_idx == IDX_W'(TAP - 1)) begin
            // A set with a missing last flag is still complete and usable.
            w_err_set   = ~load_last;
            w_idx_nxt   = '0;
            w_state_nxt = FULL;
          end else if (load_last) begin
            w_err_set   = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_wr_idx + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (commit) w_state_nxt = PENDING;
      end
      PENDING: begin
        if (sample_en) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_idx    <= '0;
      r_bank_sel  <= 1'b0;
      r_swap_done <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_idx    <= w_idx_nxt;
      r_bank_sel  <= r_bank_sel ^ w_swap;
      r_swap_done <= w_swap;
      r_err_len   <= w_err_set | (r_err_len & ~clear_err);
    end
  end

  // The shadow is the bank not selected; the active bank never sees a write.
  coeff_bank #(.WIDTH_coeff(WIDTH_coeff), .TAP(TAP), .IDX_W(IDX_W)) u_bank0 (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_beat & r_bank_sel),
    .i_waddr  (r_wr_idx),
    .i_wdata  (load_data),
    .o_coeffs (w_bank0)
  );

  coeff_bank #(.WIDTH_coeff(WIDTH_coeff), .TAP(TAP), .IDX_W(IDX_W)) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_beat & ~r_bank_sel),
    .i_waddr  (r_wr_idx),
    .i_wdata  (load_data),
    .o_coeffs (w_bank1)
  );

  assign h_out     = r_bank_sel ? w_bank1 : w_bank0;
  assign bank_sel  = r_bank_sel;
  assign swap_done = r_swap_done;
  assign err_len   = r_err_len;
  assign wr_idx    = r_wr_idx;

endmodule
